// File: rtl/startup_sequencer.sv
// Lock-qualified startup sequencer: releases gsr/prld, then gts, then gwe with programmable holds.
// Optional macro STARTUP_SEQUENCER_RELOCK_EN: lock loss after completion reruns the sequence.
module startup_sequencer #(
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned ROC_CYCLES  = 100,
  parameter int unsigned TOC_CYCLES  = 0,
  parameter int unsigned GWE_DELAY   = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_locked,
  input  logic       soft_req,
  output logic       gsr,
  output logic       prld,
  output logic       gts,
  output logic       gwe,
  output logic       done,
  output logic [2:0] state
);

  localparam int unsigned MAX_A = (LOCK_FILTER > ROC_CYCLES) ? LOCK_FILTER : ROC_CYCLES;
  localparam int unsigned MAX_B = (TOC_CYCLES > GWE_DELAY) ? TOC_CYCLES : GWE_DELAY;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] ROC_LAST  = CW'(ROC_CYCLES - 1);
  localparam logic [CW-1:0] TOC_LAST  = CW'((TOC_CYCLES > 0) ? TOC_CYCLES - 1 : 0);
  localparam logic [CW-1:0] GWE_LAST  = CW'(GWE_DELAY - 1);

  typedef enum logic [2:0] {
    S_LOCK = 3'd0,
    S_ROC  = 3'd1,
    S_TOC  = 3'd2,
    S_GWE  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_gsr;
  logic            r_gts;
  logic            r_gwe;
  logic            r_done;
  logic            w_lock_lost;
  logic            w_restart;

  // Lock loss only aborts the sequence in states that have already qualified lock
  always_comb begin
    w_lock_lost = 1'b0;
    case (r_state)
      S_ROC, S_TOC, S_GWE: w_lock_lost = ~pll_locked;
`ifdef STARTUP_SEQUENCER_RELOCK_EN
      S_DONE:              w_lock_lost = ~pll_locked;
`endif
      default:             w_lock_lost = 1'b0;
    endcase
  end

  assign w_restart = soft_req | w_lock_lost;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || w_restart) begin
      r_state <= S_LOCK;
      r_cnt   <= '0;
      r_gsr   <= 1'b1;
      r_gts   <= 1'b1;
      r_gwe   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_LOCK: begin
          if (!pll_locked) begin
            r_cnt <= '0;
          end else if (r_cnt == LOCK_LAST) begin
            r_cnt   <= '0;
            r_state <= S_ROC;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ROC: begin
          if (r_cnt == ROC_LAST) begin
            r_cnt <= '0;
            r_gsr <= 1'b0;
            // With no tristate hold, gts releases on the same edge as gsr
            if (TOC_CYCLES != 0) begin
              r_state <= S_TOC;
            end else begin
              r_gts   <= 1'b0;
              r_state <= S_GWE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_TOC: begin
          if (r_cnt == TOC_LAST) begin
            r_cnt   <= '0;
            r_gts   <= 1'b0;
            r_state <= S_GWE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GWE: begin
          if (r_cnt == GWE_LAST) begin
            r_cnt   <= '0;
            r_gwe   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_cnt <= '0;
        end
        default: begin
          r_state <= S_LOCK;
          r_cnt   <= '0;
          r_gsr   <= 1'b1;
          r_gts   <= 1'b1;
          r_gwe   <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign gsr   = r_gsr;
  assign prld  = r_gsr;
  assign gts   = r_gts;
  assign gwe   = r_gwe;
  assign done  = r_done;
  assign state = r_state;

endmodule

// File: tb/tb_startup_sequencer.sv
// Directed bench for startup_sequencer: one instance with TOC_CYCLES=20 (a), one with TOC_CYCLES=0 (b).
module tb_startup_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       pll_locked;
  logic       soft_req;
  logic       a_gsr, a_prld, a_gts, a_gwe, a_done;
  logic       b_gsr, b_prld, b_gts, b_gwe, b_done;
  logic [2:0] a_state, b_state;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  bit inv_en  = 1'b0;

  startup_sequencer #(.LOCK_FILTER(8), .ROC_CYCLES(100), .TOC_CYCLES(20), .GWE_DELAY(4)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_locked(pll_locked), .soft_req(soft_req),
    .gsr(a_gsr), .prld(a_prld), .gts(a_gts), .gwe(a_gwe), .done(a_done), .state(a_state));

  startup_sequencer #(.LOCK_FILTER(8), .ROC_CYCLES(100), .TOC_CYCLES(0), .GWE_DELAY(4)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_locked(pll_locked), .soft_req(soft_req),
    .gsr(b_gsr), .prld(b_prld), .gts(b_gts), .gwe(b_gwe), .done(b_done), .state(b_state));

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit use_b, input logic [2:0] st,
                           input logic g, input logic t, input logic w);
    if (use_b) begin
      check({tag, "_b_state"}, b_state, st);
      check({tag, "_b_gsr"},  {2'b0, b_gsr},  {2'b0, g});
      check({tag, "_b_prld"}, {2'b0, b_prld}, {2'b0, g});
      check({tag, "_b_gts"},  {2'b0, b_gts},  {2'b0, t});
      check({tag, "_b_gwe"},  {2'b0, b_gwe},  {2'b0, w});
      check({tag, "_b_done"}, {2'b0, b_done}, {2'b0, w});
    end else begin
      check({tag, "_a_state"}, a_state, st);
      check({tag, "_a_gsr"},  {2'b0, a_gsr},  {2'b0, g});
      check({tag, "_a_prld"}, {2'b0, a_prld}, {2'b0, g});
      check({tag, "_a_gts"},  {2'b0, a_gts},  {2'b0, t});
      check({tag, "_a_gwe"},  {2'b0, a_gwe},  {2'b0, w});
      check({tag, "_a_done"}, {2'b0, a_done}, {2'b0, w});
    end
  endtask

  // Advance to clock edge e (edge 1 is the first edge with reset released), then settle
  task automatic run_to(input int e);
    while (edge_n < e) begin
      @(posedge sys_clk);
      edge_n++;
    end
    #1;
  endtask

  // Release ordering and prld tracking hold on every cycle
  always @(negedge sys_clk) begin
    if (inv_en) begin
      check("inv_a_gwe_gts", {2'b0, a_gwe & a_gts}, 3'd0);
      check("inv_a_gts_gsr", {2'b0, ~a_gts & a_gsr}, 3'd0);
      check("inv_a_prld",    {2'b0, a_prld}, {2'b0, a_gsr});
      check("inv_b_gwe_gts", {2'b0, b_gwe & b_gts}, 3'd0);
      check("inv_b_gts_gsr", {2'b0, ~b_gts & b_gsr}, 3'd0);
      check("inv_b_prld",    {2'b0, b_prld}, {2'b0, b_gsr});
    end
  end

  initial begin
    sys_rst_n  = 1'b0;
    pll_locked = 1'b0;
    soft_req   = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_all("reset", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_all("reset", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    inv_en     = 1'b1;
    sys_rst_n  = 1'b1;
    pll_locked = 1'b1;

    // Nominal sequence on both instances
    run_to(7);   check("filt7_a", a_state, 3'd0); check("filt7_b", b_state, 3'd0);
    run_to(8);   check("filt8_a", a_state, 3'd1); check("filt8_b", b_state, 3'd1);
    run_to(107); check_all("roc107", 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
                 check_all("roc107", 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
    run_to(108); check_all("gsr108", 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
                 check_all("gsr108", 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    run_to(111); check("gwe111_b", {2'b0, b_gwe}, 3'd0);
    run_to(112); check_all("gwe112", 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
    run_to(127); check_all("toc127", 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    run_to(128); check_all("gts128", 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    run_to(131); check("gwe131_a", {2'b0, a_gwe}, 3'd0);
    run_to(132); check_all("done132", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);

    // soft_req restart from S_DONE
    run_to(140); soft_req = 1'b1;
    run_to(141); soft_req = 1'b0;
    check_all("soft141", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_all("soft141", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    run_to(148); check("refilt148_a", a_state, 3'd0);
    run_to(149); check("refilt149_a", a_state, 3'd1);
    run_to(248); check("regsr248_a", {2'b0, a_gsr}, 3'd1);
    run_to(249); check_all("regsr249", 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    run_to(269); check_all("regts269", 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    run_to(272); check("regwe272_a", {2'b0, a_gwe}, 3'd0);
    run_to(273); check_all("redone273", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);

    // Single-cycle lock loss while in S_ROC
    run_to(279); soft_req = 1'b1;
    run_to(280); soft_req = 1'b0;
    check("soft280_a", a_state, 3'd0);
    run_to(288); check("roc288_a", a_state, 3'd1); check("roc288_b", b_state, 3'd1);
    run_to(299); pll_locked = 1'b0;
    run_to(300); pll_locked = 1'b1;
    check_all("loss300", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_all("loss300", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    run_to(307); check("loss307_a", a_state, 3'd0);
    run_to(308); check("loss308_a", a_state, 3'd1);
    run_to(407); check("loss407_a", {2'b0, a_gsr}, 3'd1);
    run_to(408); check_all("loss408", 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    run_to(432); check_all("loss432", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);

    // Lock glitch inside the filter window restarts the count
    run_to(439); soft_req = 1'b1;
    run_to(440); soft_req = 1'b0;
    check("soft440_a", a_state, 3'd0); check("soft440_b", b_state, 3'd0);
    run_to(444); pll_locked = 1'b0;
    run_to(445); pll_locked = 1'b1;
    check("glitch445_a", a_state, 3'd0);
    run_to(452); check("glitch452_a", a_state, 3'd0);
    run_to(453); check("glitch453_a", a_state, 3'd1);
    run_to(552); check("glitch552_a", {2'b0, a_gsr}, 3'd1);
    run_to(553); check_all("glitch553", 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    run_to(577); check_all("glitch577", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);

    // Synchronous reset from S_DONE and mid-sequence
    run_to(579); sys_rst_n = 1'b0;
    run_to(580); sys_rst_n = 1'b1;
    check_all("rst580", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_all("rst580", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    run_to(587); check("rst587_a", a_state, 3'd0);
    run_to(588); check("rst588_a", a_state, 3'd1);
    run_to(619); sys_rst_n = 1'b0;
    run_to(620); sys_rst_n = 1'b1;
    check_all("rst620", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    run_to(627); check("rst627_a", a_state, 3'd0);
    run_to(628); check("rst628_a", a_state, 3'd1);

    // soft_req and lock loss on the same edge
    run_to(649); soft_req = 1'b1; pll_locked = 1'b0;
    run_to(650); soft_req = 1'b0; pll_locked = 1'b1;
    check_all("both650", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_all("both650", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    run_to(758); check_all("both758", 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    run_to(782); check_all("both782", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
                 check_all("both782", 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);

    // Lock loss in S_DONE held for 200 cycles
    run_to(789); pll_locked = 1'b0;
    run_to(790);
`ifdef STARTUP_SEQUENCER_RELOCK_EN
    check_all("done_loss790", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    check_all("done_loss790", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    for (int e = 791; e <= 989; e++) begin
      run_to(e);
      check("done_loss_hold_a", a_state, 3'd0);
    end
`else
    check_all("done_loss790", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
    check_all("done_loss790", 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
    for (int e = 791; e <= 989; e++) begin
      run_to(e);
      check("done_loss_hold_a", {a_state[1:0], a_gwe}, 3'b001);
    end
    check_all("done_loss989", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
`endif
    pll_locked = 1'b1;
    run_to(1000);

    inv_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
